// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and the queued-write entry type for the register-file write arbiter.
package regfile_write_arbiter_pkg;
   localparam int REG_ADDR_W     = 5;
   localparam int DATA_W         = 32;
   localparam int REG_NUM        = 32;
   localparam int WB_QUEUE_DEPTH = 4;

   typedef struct packed {
      logic                  live;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/regfile_write_arbiter_aux_queue.sv
// Circular buffer of auxiliary writes; entries can be killed by address so an older
// queued write never lands on top of a newer pipeline write to the same register.
module regfile_write_arbiter_aux_queue
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [REG_ADDR_W-1:0] push_addr_i,
   input  logic [DATA_W-1:0]     push_data_i,
   input  logic                  pop_i,
   input  logic                  kill_en_i,
   input  logic [REG_ADDR_W-1:0] kill_addr_i,
   output wb_entry_t             head_o,
   output logic [CNT_W-1:0]      count_o,
   output logic [REG_NUM-1:0]    pending_mask_o
);
   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         // Kill first so a same-cycle push (younger than the pipe write) survives it.
         for (int i = 0; i < DEPTH; i++)
            if (kill_en_i && mem_q[i].addr == kill_addr_i) mem_q[i].live <= 1'b0;
         if (pop_i) begin
            mem_q[head_q].live <= 1'b0;
            head_q             <= head_q + PTR_W'(1);
         end
         if (push_i) begin
            mem_q[tail_q] <= '{live: 1'b1, addr: push_addr_i, data: push_data_i};
            tail_q        <= tail_q + PTR_W'(1);
         end
         unique case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Freed slots have live cleared, so only occupied live entries contribute.
   always_comb begin
      pending_mask_o = '0;
      for (int i = 0; i < DEPTH; i++)
         if (mem_q[i].live) pending_mask_o[mem_q[i].addr] = 1'b1;
      pending_mask_o[0] = 1'b0;
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole driver of the register-file write port: pipeline writeback wins, queued aux
// writes drain in idle pipe cycles, one registered write per cycle at most.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int QUEUE_DEPTH = WB_QUEUE_DEPTH,
   parameter int CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  pipe_write_en_i,
   input  logic [REG_ADDR_W-1:0] pipe_write_addr_i,
   input  logic [DATA_W-1:0]     pipe_write_data_i,
   input  logic                  aux_valid_i,
   output logic                  aux_ready_o,
   input  logic [REG_ADDR_W-1:0] aux_addr_i,
   input  logic [DATA_W-1:0]     aux_data_i,
   output logic                  write_en_o,
   output logic [REG_ADDR_W-1:0] write_addr_o,
   output logic [DATA_W-1:0]     write_data_o,
   output logic [REG_NUM-1:0]    pending_mask_o,
   output logic [CNT_W-1:0]      queue_count_o
);
   wb_entry_t             head;
   logic                  pipe_acc, pop, push, pop_live;
   logic                  write_en_q, write_en_d;
   logic [REG_ADDR_W-1:0] write_addr_q, write_addr_d;
   logic [DATA_W-1:0]     write_data_q, write_data_d;

   assign pipe_acc    = pipe_write_en_i && (pipe_write_addr_i != '0);
   assign pop         = !pipe_acc && (queue_count_o != '0);
   assign pop_live    = pop && head.live;
   // No bypass: a full queue refuses even when it is about to pop.
   assign aux_ready_o = !rst_i && (queue_count_o < CNT_W'(QUEUE_DEPTH));
   assign push        = aux_valid_i && aux_ready_o && (aux_addr_i != '0);

   regfile_write_arbiter_aux_queue #(
      .DEPTH (QUEUE_DEPTH),
      .CNT_W (CNT_W)
   ) u_queue (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .push_i         (push),
      .push_addr_i    (aux_addr_i),
      .push_data_i    (aux_data_i),
      .pop_i          (pop),
      .kill_en_i      (pipe_acc),
      .kill_addr_i    (pipe_write_addr_i),
      .head_o         (head),
      .count_o        (queue_count_o),
      .pending_mask_o (pending_mask_o)
   );

   always_comb begin
      write_en_d   = pipe_acc || pop_live;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      if (pipe_acc) begin
         write_addr_d = pipe_write_addr_i;
         write_data_d = pipe_write_data_i;
      end else if (pop_live) begin
         write_addr_d = head.addr;
         write_data_d = head.data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
      end else begin
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
      end
   end

   assign write_en_o   = write_en_q;
   assign write_addr_o = write_addr_q;
   assign write_data_o = write_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: each task drives a scenario and checks
// {write_en, write_addr, write_data, queue_count, pending_mask} cycle by cycle.
module tb_regfile_write_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_en;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        aux_valid, aux_ready;
   logic [4:0]  aux_addr;
   logic [31:0] aux_data;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [31:0] pm;
   logic [2:0]  qc;
   logic [72:0] obs, exp_v;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .pipe_write_en_i   (pipe_en),
      .pipe_write_addr_i (pipe_addr),
      .pipe_write_data_i (pipe_data),
      .aux_valid_i       (aux_valid),
      .aux_ready_o       (aux_ready),
      .aux_addr_i        (aux_addr),
      .aux_data_i        (aux_data),
      .write_en_o        (we),
      .write_addr_o      (wa),
      .write_data_o      (wd),
      .pending_mask_o    (pm),
      .queue_count_o     (qc)
   );

   assign obs = {we, wa, wd, qc, pm};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pipe_en = 0; pipe_addr = 0; pipe_data = 0;
      aux_valid = 0; aux_addr = 0; aux_data = 0;
      tick(); tick();
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_state: got %h exp %h", obs, exp_v); end
      checks++;
      if (aux_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", aux_ready); end
      rst = 1'b0; #1;
      checks++;
      if (aux_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b exp 1", aux_ready); end
   endtask

   task automatic test_pipe_only();
      pipe_en = 1; pipe_addr = 5; pipe_data = 32'h11;
      tick();
      exp_v = {1'b1, 5'd5, 32'h11, 3'd0, 32'h0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pipe_write: got %h exp %h", obs, exp_v); end
      pipe_en = 0;
      tick();
      exp_v = {1'b0, 5'd5, 32'h11, 3'd0, 32'h0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pipe_idle_hold: got %h exp %h", obs, exp_v); end
   endtask

   task automatic test_aux_drain();
      logic [72:0] e [4];
      e[0] = {1'b0, 5'd5, 32'h11, 3'd1, 32'h0000_0008};
      e[1] = {1'b1, 5'd3, 32'hAA, 3'd1, 32'h0000_0010};
      e[2] = {1'b1, 5'd4, 32'hBB, 3'd0, 32'h0};
      e[3] = {1'b0, 5'd4, 32'hBB, 3'd0, 32'h0};
      aux_valid = 1; aux_addr = 3; aux_data = 32'hAA;
      tick();
      checks++;
      if (obs !== e[0]) begin errors++; $display("FAIL drain_0: got %h exp %h", obs, e[0]); end
      aux_addr = 4; aux_data = 32'hBB;
      tick();
      checks++;
      if (obs !== e[1]) begin errors++; $display("FAIL drain_1: got %h exp %h", obs, e[1]); end
      aux_valid = 0;
      for (int i = 2; i < 4; i++) begin
         tick();
         checks++;
         if (obs !== e[i]) begin errors++; $display("FAIL drain_%0d: got %h exp %h", i, obs, e[i]); end
      end
   endtask

   task automatic test_priority();
      logic [72:0] e [4];
      e[0] = {1'b1, 5'd8, 32'h80, 3'd1, 32'h80};
      e[1] = {1'b1, 5'd8, 32'h81, 3'd1, 32'h80};
      e[2] = {1'b1, 5'd8, 32'h82, 3'd1, 32'h80};
      e[3] = {1'b1, 5'd7, 32'h01, 3'd0, 32'h0};
      aux_valid = 1; aux_addr = 7; aux_data = 32'h1;
      pipe_en = 1; pipe_addr = 8;
      for (int i = 0; i < 4; i++) begin
         pipe_en = (i < 3); pipe_data = 32'h80 + 32'(i);
         tick();
         aux_valid = 0;
         checks++;
         if (obs !== e[i]) begin errors++; $display("FAIL priority_%0d: got %h exp %h", i, obs, e[i]); end
      end
   endtask

   task automatic test_kill();
      logic [72:0] e [3];
      e[0] = {1'b0, 5'd7, 32'h01, 3'd1, 32'h0000_0200};
      e[1] = {1'b1, 5'd9, 32'h06, 3'd1, 32'h0};
      e[2] = {1'b0, 5'd9, 32'h06, 3'd0, 32'h0};
      aux_valid = 1; aux_addr = 9; aux_data = 32'h5;
      tick();
      aux_valid = 0;
      checks++;
      if (obs !== e[0]) begin errors++; $display("FAIL kill_push: got %h exp %h", obs, e[0]); end
      pipe_en = 1; pipe_addr = 9; pipe_data = 32'h6;
      tick();
      pipe_en = 0;
      checks++;
      if (obs !== e[1]) begin errors++; $display("FAIL kill_pipe: got %h exp %h", obs, e[1]); end
      tick();
      checks++;
      if (obs !== e[2]) begin errors++; $display("FAIL kill_pop_silent: got %h exp %h", obs, e[2]); end
   endtask

   task automatic test_full_same_cycle();
      logic [31:0] m;
      logic [72:0] e [6];
      m = 0;
      pipe_en = 1; pipe_addr = 1; aux_valid = 1;
      for (int i = 0; i < 4; i++) begin
         pipe_data = 32'(i); aux_addr = 5'(10 + i); aux_data = 32'hA0 + 32'(i);
         #1;
         checks++;
         if (aux_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b exp 1", i, aux_ready); end
         tick();
         m = m | (32'h1 << (10 + i));
         exp_v = {1'b1, 5'd1, 32'(i), 3'(i + 1), m};
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL fill_%0d: got %h exp %h", i, obs, exp_v); end
      end
      // Full: r2 offered while the queue pops, must be refused.
      pipe_en = 0; aux_addr = 2; aux_data = 32'h33;
      #1;
      checks++;
      if (aux_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", aux_ready); end
      e[0] = {1'b1, 5'd10, 32'hA0, 3'd3, 32'h0000_3800};
      e[1] = {1'b1, 5'd2,  32'h22, 3'd4, 32'h0000_3804};
      e[2] = {1'b1, 5'd11, 32'hA1, 3'd3, 32'h0000_3004};
      e[3] = {1'b1, 5'd12, 32'hA2, 3'd2, 32'h0000_2004};
      e[4] = {1'b1, 5'd13, 32'hA3, 3'd1, 32'h0000_0004};
      e[5] = {1'b1, 5'd2,  32'h33, 3'd0, 32'h0};
      tick();
      checks++;
      if (obs !== e[0]) begin errors++; $display("FAIL full_no_bypass: got %h exp %h", obs, e[0]); end
      pipe_en = 1; pipe_addr = 2; pipe_data = 32'h22;
      tick();
      pipe_en = 0; aux_valid = 0;
      checks++;
      if (obs !== e[1]) begin errors++; $display("FAIL same_cycle_push: got %h exp %h", obs, e[1]); end
      for (int i = 2; i < 6; i++) begin
         tick();
         checks++;
         if (obs !== e[i]) begin errors++; $display("FAIL full_drain_%0d: got %h exp %h", i, obs, e[i]); end
      end
   endtask

   task automatic test_reset_mid();
      pipe_en = 1; pipe_addr = 1; aux_valid = 1;
      for (int i = 0; i < 3; i++) begin
         pipe_data = 32'h50 + 32'(i); aux_addr = 5'(20 + i); aux_data = 32'hC0 + 32'(i);
         tick();
      end
      pipe_en = 0; aux_valid = 0;
      checks++;
      if (qc !== 3'd3 || pm !== 32'h0070_0000) begin
         errors++; $display("FAIL pre_reset_queue: got %0d/%h exp 3/00700000", qc, pm);
      end
      rst = 1; #1;
      checks++;
      if (aux_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b exp 0", aux_ready); end
      tick();
      rst = 0;
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL mid_reset_state: got %h exp %h", obs, exp_v); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL post_reset_%0d: got %h exp %h", i, obs, exp_v); end
      end
      // Writes to r0 from either side leave no trace.
      pipe_en = 1; pipe_addr = 0; pipe_data = 32'hDEAD;
      aux_valid = 1; aux_addr = 0; aux_data = 32'hBEEF;
      #1;
      checks++;
      if (aux_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b exp 1", aux_ready); end
      tick();
      pipe_en = 0; aux_valid = 0;
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL r0_ignored: got %h exp %h", obs, exp_v); end
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL r0_no_late: got %h exp %h", obs, exp_v); end
   endtask

   initial begin
      test_reset();
      test_pipe_only();
      test_aux_drain();
      test_priority();
      test_kill();
      test_full_same_cycle();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
